// File: rtl/swim_pkg.sv
// Shared constants, state encoding and step-descriptor types for the SWIM
// command scheduler.
package swim_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] OP_ENTRY = 8'h01;
  localparam logic [DATA_W-1:0] OP_SRST  = 8'h02;
  localparam logic [DATA_W-1:0] OP_ROTF  = 8'h03;
  localparam logic [DATA_W-1:0] OP_WOTF  = 8'h04;

  localparam logic [2:0] SWIM_SRST = 3'b000;
  localparam logic [2:0] SWIM_ROTF = 3'b001;
  localparam logic [2:0] SWIM_WOTF = 3'b010;

  localparam logic [DATA_W-1:0] RSP_OK_BASE   = 8'h80;
  localparam logic [DATA_W-1:0] RSP_NACK_BASE = 8'hE0;
  localparam logic [DATA_W-1:0] RSP_BADOP     = 8'hEE;
  localparam logic [DATA_W-1:0] RSP_TMO_BASE  = 8'hF0;

  // Byte count N of the ROTF/WOTF transfers; this scheduler always moves one byte
  localparam logic [DATA_W-1:0] SWIM_N_ONE = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_ENTRY_GO,
    ST_ENTRY_WAIT,
    ST_FRAME,
    ST_FRAME_WAIT,
    ST_RESP,
    ST_RESP2
  } state_e;

  typedef enum logic [2:0] {
    SRC_CMD,
    SRC_N,
    SRC_ARG0,
    SRC_ARG1,
    SRC_ARG2,
    SRC_ARG3,
    SRC_NONE
  } src_e;

  typedef struct packed {
    logic       is_cmd;
    logic       rx;
    src_e       src;
    logic [2:0] cmd;
    logic       last;
  } step_t;

endpackage

// File: rtl/swim_step_rom.sv
// Maps (opcode, step) to the frame descriptor for that step of an SRST,
// ROTF or WOTF transaction.
module swim_step_rom
  import swim_pkg::*;
(
  input  logic [DATA_W-1:0] opcode,
  input  logic [2:0]        step,
  output step_t             st
);

  always_comb begin
    st = '{is_cmd: 1'b0, rx: 1'b0, src: SRC_NONE, cmd: 3'b000, last: 1'b1};
    case (opcode)
      OP_SRST: begin
        st.is_cmd = 1'b1;
        st.src    = SRC_CMD;
        st.cmd    = SWIM_SRST;
      end
      OP_ROTF, OP_WOTF: begin
        st.last = 1'b0;
        case (step)
          3'd0: begin
            st.is_cmd = 1'b1;
            st.src    = SRC_CMD;
            st.cmd    = (opcode == OP_ROTF) ? SWIM_ROTF : SWIM_WOTF;
          end
          3'd1: st.src = SRC_N;
          3'd2: st.src = SRC_ARG0;
          3'd3: st.src = SRC_ARG1;
          3'd4: st.src = SRC_ARG2;
          3'd5: begin
            st.last = 1'b1;
            // ROTF ends with a target-to-host byte instead of a payload byte
            if (opcode == OP_ROTF) begin
              st.rx  = 1'b1;
              st.src = SRC_NONE;
            end else begin
              st.src = SRC_ARG3;
            end
          end
          default: st.last = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/swim_cmd_sched.sv
// Host command scheduler driving the SWIM entry generator and frame engine.
// Optional watchdog on the WAIT states: define SWIM_TIMEOUT_EN.
module swim_cmd_sched
  import swim_pkg::*;
#(
  parameter int MAX_RETRY   = 4,
  parameter int TIMEOUT_CYC = 480000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              entry_start,
  input  logic              entry_done,
  output logic              frm_start,
  output logic              frm_is_cmd,
  output logic              frm_rx,
  output logic [DATA_W-1:0] frm_data,
  input  logic              frm_done,
  input  logic              frm_ack,
  input  logic [DATA_W-1:0] frm_rdata,
  output logic              busy
);

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_e            state;
  logic [DATA_W-1:0] opcode;
  logic [DATA_W-1:0] arg [4];
  logic [1:0]        arg_cnt;
  logic [2:0]        step;
  logic [3:0]        retry;
  logic [DATA_W-1:0] rsp2_data;
  logic              rsp2_pend;
  step_t             st;
  logic [DATA_W-1:0] frm_payload;
  logic              last_arg;
  logic              tmo;

  swim_step_rom u_step_rom (
    .opcode (opcode),
    .step   (step),
    .st     (st)
  );

  always_comb begin
    case (st.src)
      SRC_CMD:  frm_payload = {5'b00000, st.cmd};
      SRC_N:    frm_payload = SWIM_N_ONE;
      SRC_ARG0: frm_payload = arg[0];
      SRC_ARG1: frm_payload = arg[1];
      SRC_ARG2: frm_payload = arg[2];
      SRC_ARG3: frm_payload = arg[3];
      default:  frm_payload = '0;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE) || (state == ST_ARGS);
  assign busy      = (state != ST_IDLE);
  assign last_arg  = (arg_cnt == ((opcode == OP_WOTF) ? 2'd3 : 2'd2));

`ifdef SWIM_TIMEOUT_EN
  localparam logic [18:0] TMO_LAST = 19'(TIMEOUT_CYC - 1);
  logic [18:0] wdog;

  // Counter sits at zero outside the WAIT states, so every entry starts fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == ST_ENTRY_WAIT || state == ST_FRAME_WAIT) begin
      wdog <= wdog + 19'd1;
    end else begin
      wdog <= '0;
    end
  end

  assign tmo = (state == ST_ENTRY_WAIT || state == ST_FRAME_WAIT) && (wdog == TMO_LAST);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      opcode      <= '0;
      arg         <= '{default: '0};
      arg_cnt     <= '0;
      step        <= '0;
      retry       <= '0;
      rsp2_data   <= '0;
      rsp2_pend   <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      entry_start <= 1'b0;
      frm_start   <= 1'b0;
      frm_is_cmd  <= 1'b0;
      frm_rx      <= 1'b0;
      frm_data    <= '0;
    end else begin
      entry_start <= 1'b0;
      frm_start   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            opcode    <= cmd_data;
            arg_cnt   <= '0;
            step      <= '0;
            retry     <= '0;
            rsp2_pend <= 1'b0;
            case (cmd_data)
              OP_ENTRY:         state <= ST_ENTRY_GO;
              OP_SRST:          state <= ST_FRAME;
              OP_ROTF, OP_WOTF: state <= ST_ARGS;
              default: begin
                rsp_data  <= RSP_BADOP;
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
              end
            endcase
          end
        end
        ST_ARGS: begin
          if (cmd_valid) begin
            arg[arg_cnt] <= cmd_data;
            arg_cnt      <= arg_cnt + 2'd1;
            if (last_arg) state <= ST_FRAME;
          end
        end
        ST_ENTRY_GO: begin
          entry_start <= 1'b1;
          state       <= ST_ENTRY_WAIT;
        end
        ST_ENTRY_WAIT: begin
          if (tmo) begin
            rsp_data  <= RSP_TMO_BASE | opcode;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (entry_done) begin
            rsp_data  <= RSP_OK_BASE | opcode;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_FRAME: begin
          frm_start  <= 1'b1;
          frm_is_cmd <= st.is_cmd;
          frm_rx     <= st.rx;
          frm_data   <= frm_payload;
          state      <= ST_FRAME_WAIT;
        end
        ST_FRAME_WAIT: begin
          if (tmo) begin
            rsp_data  <= RSP_TMO_BASE | opcode;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (frm_done) begin
            if (frm_ack) begin
              retry <= '0;
              if (st.last) begin
                rsp_data  <= RSP_OK_BASE | opcode;
                rsp_valid <= 1'b1;
                rsp2_data <= frm_rdata;
                rsp2_pend <= st.rx;
                state     <= ST_RESP;
              end else begin
                step  <= step + 3'd1;
                state <= ST_FRAME;
              end
            end else if (retry < RETRY_LIM) begin
              retry <= retry + 4'd1;
              state <= ST_FRAME;
            end else begin
              rsp_data  <= RSP_NACK_BASE | opcode;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (rsp2_pend) begin
              rsp_data  <= rsp2_data;
              rsp2_pend <= 1'b0;
              state     <= ST_RESP2;
            end else begin
              rsp_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_RESP2: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swim_cmd_sched.sv
// Randomized bench for swim_cmd_sched with behavioural SWIM line models and a
// transaction-level reference of the expected frames and responses.
module tb_swim_cmd_sched;

  localparam int REF_MAX_RETRY = 4;
  localparam int TB_TIMEOUT    = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       entry_start;
  logic       entry_done = 1'b0;
  logic       frm_start;
  logic       frm_is_cmd;
  logic       frm_rx;
  logic [7:0] frm_data;
  logic       frm_done = 1'b0;
  logic       frm_ack = 1'b0;
  logic [7:0] frm_rdata = 8'h00;
  logic       busy;

  swim_cmd_sched #(
    .MAX_RETRY   (REF_MAX_RETRY),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .entry_start (entry_start),
    .entry_done  (entry_done),
    .frm_start   (frm_start),
    .frm_is_cmd  (frm_is_cmd),
    .frm_rx      (frm_rx),
    .frm_data    (frm_data),
    .frm_done    (frm_done),
    .frm_ack     (frm_ack),
    .frm_rdata   (frm_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [9:0] frames[$];
  logic [9:0] exp_frm[$];
  logic [7:0] exp_rsp[$];
  int         exp_entry;
  int         n_entry = 0;
  int         nack_left = 0;
  int         overlap = 0;
  logic [7:0] rx_byte = 8'h00;
  bit         frm_hang = 1'b0;
  bit         entry_hang = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Frame engine: logs each frame, answers after a random latency
  always begin : frm_model
    int d;
    logic [7:0] held;
    @(posedge clk); #1;
    if (frm_start) begin
      frames.push_back({frm_rx, frm_is_cmd, frm_data});
      held = frm_data;
      if (!frm_hang) begin
        d = $urandom_range(1, 5);
        repeat (d) @(posedge clk);
        #1;
        check("frm_data_stable", frm_data, held);
        frm_done  = 1'b1;
        frm_ack   = (nack_left == 0);
        if (nack_left > 0) nack_left--;
        frm_rdata = frm_rx ? rx_byte : 8'($urandom);
        @(posedge clk); #1;
        frm_done = 1'b0;
        frm_ack  = 1'b0;
      end
    end
  end

  // Entry generator: done pulse 20 cycles after the start pulse
  always begin : entry_model
    @(posedge clk); #1;
    if (entry_start) begin
      n_entry++;
      if (!entry_hang) begin
        repeat (19) @(posedge clk);
        #1; entry_done = 1'b1;
        @(posedge clk); #1; entry_done = 1'b0;
      end
    end
  end

  always @(negedge clk) if (entry_start && frm_start) overlap++;

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bit rdy;
    cmd_data  = b;
    cmd_valid = 1'b1;
    rdy = cmd_ready;
    while (!rdy && w < 200) begin
      @(posedge clk); #1; w++;
      rdy = cmd_ready;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!rdy) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic get_rsp(output logic [7:0] b, output bit ok);
    int w = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (!rsp_valid && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    if (!rsp_valid) return;
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    b = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ok = 1'b1;
  endtask

  // Transaction-level reference: frame list and response bytes per command
  task automatic build_expect(input logic [7:0] op, input logic [31:0] args, input int nacks,
                              input logic [7:0] rxb);
    logic [9:0] seq[$];
    int attempts;
    exp_frm.delete();
    exp_rsp.delete();
    exp_entry = 0;
    seq.delete();
    case (op)
      8'h01: begin exp_entry = 1; exp_rsp.push_back(8'h81); end
      8'h02: seq = '{{2'b01, 8'h00}};
      8'h03: seq = '{{2'b01, 8'h01}, {2'b00, 8'h01}, {2'b00, args[31:24]},
                     {2'b00, args[23:16]}, {2'b00, args[15:8]}, {2'b10, 8'h00}};
      8'h04: seq = '{{2'b01, 8'h02}, {2'b00, 8'h01}, {2'b00, args[31:24]},
                     {2'b00, args[23:16]}, {2'b00, args[15:8]}, {2'b00, args[7:0]}};
      default: exp_rsp.push_back(8'hEE);
    endcase
    if (seq.size() > 0) begin
      attempts = (nacks > REF_MAX_RETRY) ? REF_MAX_RETRY + 1 : nacks + 1;
      for (int i = 0; i < attempts; i++) exp_frm.push_back(seq[0]);
      if (nacks > REF_MAX_RETRY) begin
        exp_rsp.push_back(8'hE0 + op);
      end else begin
        for (int i = 1; i < seq.size(); i++) exp_frm.push_back(seq[i]);
        exp_rsp.push_back(8'h80 + op);
        if (op == 8'h03) exp_rsp.push_back(rxb);
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic [7:0] op, input logic [31:0] args,
                         input int nacks, input logic [7:0] rxb);
    logic [7:0] b;
    bit ok;
    int nargs;
    frames.delete();
    n_entry   = 0;
    nack_left = nacks;
    rx_byte   = rxb;
    build_expect(op, args, nacks, rxb);
    send_byte(op);
    nargs = (op == 8'h03) ? 3 : (op == 8'h04) ? 4 : 0;
    for (int i = 0; i < nargs; i++) send_byte(args[31-8*i -: 8]);
    for (int i = 0; i < exp_rsp.size(); i++) begin
      get_rsp(b, ok);
      check({tag, " rsp_arrived"}, ok, 1);
      check({tag, " rsp_byte"}, b, exp_rsp[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, " busy_after"}, busy, 0);
    check({tag, " rsp_valid_after"}, rsp_valid, 0);
    check({tag, " entry_count"}, n_entry, exp_entry);
    check({tag, " frame_count"}, frames.size(), exp_frm.size());
    for (int i = 0; i < exp_frm.size() && i < frames.size(); i++) begin
      if (exp_frm[i][9]) check({tag, " frame_kind"}, frames[i][9:8], exp_frm[i][9:8]);
      else check({tag, " frame"}, frames[i], exp_frm[i]);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] op;
    bit ok, stable;
    int w;

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_data", rsp_data, 0);
    check("rst entry_start", entry_start, 0);
    check("rst frm_start", frm_start, 0);
    check("rst frm_data", frm_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle cmd_ready", cmd_ready, 1);

    run_txn("entry", 8'h01, 32'h0, 0, 8'h00);
    run_txn("wotf", 8'h04, 32'h007F80AA, 0, 8'h00);
    run_txn("rotf", 8'h03, 32'h00500500, 0, 8'h5C);
    run_txn("srst_nack2", 8'h02, 32'h0, 2, 8'h00);
    run_txn("srst_nack4", 8'h02, 32'h0, 4, 8'h00);
    run_txn("srst_nack5", 8'h02, 32'h0, 5, 8'h00);
    run_txn("wotf_nack5", 8'h04, 32'h11223344, 5, 8'h00);

    // Unknown opcode with the host refusing the response for 100 cycles
    frames.delete();
    n_entry = 0;
    send_byte(8'h7A);
    w = 0;
    while (!rsp_valid && w < 100) begin @(posedge clk); #1; w++; end
    stable = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hEE || cmd_ready !== 1'b0) stable = 1'b0;
    end
    check("badop hold_stable", stable, 1);
    get_rsp(b, ok);
    check("badop rsp_byte", b, 8'hEE);
    check("badop no_entry", n_entry, 0);
    check("badop no_frames", frames.size(), 0);

    // Reset while a WOTF frame is outstanding
    frm_hang = 1'b1;
    frames.delete();
    send_byte(8'h04);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i));
    w = 0;
    while (frames.size() == 0 && w < 100) begin @(posedge clk); #1; w++; end
    check("rst_mid frame_seen", frames.size() > 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid busy_before", busy, 1);
    pulse_reset();
    check("rst_mid busy", busy, 0);
    check("rst_mid rsp_valid", rsp_valid, 0);
    check("rst_mid cmd_ready", cmd_ready, 1);
    check("rst_mid frm_start", frm_start, 0);
    frm_hang = 1'b0;

    // Reset while arguments are half received; the next command starts clean
    send_byte(8'h03);
    send_byte(8'h11);
    pulse_reset();
    check("rst_args busy", busy, 0);
    run_txn("rotf_after_rst", 8'h03, 32'h0A0B0C00, 0, 8'hC3);

`ifdef SWIM_TIMEOUT_EN
    entry_hang = 1'b1;
    n_entry = 0;
    send_byte(8'h01);
    get_rsp(b, ok);
    check("tmo rsp_arrived", ok, 1);
    check("tmo rsp_byte", b, 8'hF1);
    entry_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("tmo busy_after", busy, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        default: begin
          op = 8'($urandom);
          while (op >= 8'h01 && op <= 8'h04) op = 8'($urandom);
        end
      endcase
      run_txn($sformatf("rand%0d op%02h", t, op), op, $urandom, $urandom_range(0, 5),
              8'($urandom));
    end

    check("start_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
